// File: rtl/des_key_schedule_if.sv
// Handshake bundle between key-load logic, the DES key schedule and the round datapath.
interface des_key_schedule_if #(
    parameter int unsigned ROUND_IDX_W = 5
);
    logic                   i_start;
    logic                   i_decrypt;
    logic [55:0]            i_key;
    logic                   i_clear;
    logic                   i_ready;
    logic                   o_valid;
    logic [47:0]            o_round_key;
    logic [ROUND_IDX_W-1:0] o_round_idx;
    logic                   o_busy;
    logic                   o_done;

    // slave is the key schedule itself; master is whoever drives/consumes it
    modport slave (
        input  i_start, i_decrypt, i_key, i_clear, i_ready,
        output o_valid, o_round_key, o_round_idx, o_busy, o_done
    );
    modport master (
        output i_start, i_decrypt, i_key, i_clear, i_ready,
        input  o_valid, o_round_key, o_round_idx, o_busy, o_done
    );
endinterface

// File: rtl/des_key_schedule.sv
// Sequential DES round-key generator: one PC-2 compressed key per handshake,
// in encrypt (K1..KN) or decrypt (KN..K1) order from a single PC-1 key load.
module des_key_schedule #(
    parameter int unsigned NUM_ROUNDS     = 16,
    parameter logic [15:0] SHIFT_SCHEDULE = 16'h7EFC,
    parameter int unsigned ROUND_IDX_W    = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    des_key_schedule_if.slave ks
);
    localparam int unsigned HALF_W  = 28;
    localparam int unsigned KEY_W   = 2 * HALF_W;
    localparam int unsigned SCHED_W = 1 << ROUND_IDX_W;
    localparam logic [SCHED_W-1:0] SCHED = SCHED_W'(SHIFT_SCHEDULE);

    // Net rotation after all rounds; decrypt starts from the last round's C/D.
    function automatic int unsigned total_shift();
        logic [15:0] s;
        int unsigned sum;
        s   = SHIFT_SCHEDULE;
        sum = 0;
        for (int unsigned i = 0; i < NUM_ROUNDS; i++) begin
            sum = sum + (s[0] ? 32'd2 : 32'd1);
            s   = s >> 1;
        end
        return sum % HALF_W;
    endfunction

    localparam logic [4:0] T_ROT = 5'(total_shift());

    function automatic logic [4:0] shamt(input logic two);
        return two ? 5'd2 : 5'd1;
    endfunction

    function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x, input logic [4:0] n);
        logic [KEY_W-1:0] dbl;
        dbl = {x, x} >> n;
        return dbl[HALF_W-1:0];
    endfunction

    function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x, input logic [4:0] n);
        logic [KEY_W-1:0] dbl;
        dbl = {x, x} << n;
        return dbl[KEY_W-1:HALF_W];
    endfunction

    function automatic logic [KEY_W-1:0] rotl56(input logic [KEY_W-1:0] cd, input logic [4:0] n);
        return {rotl28(cd[KEY_W-1:HALF_W], n), rotl28(cd[HALF_W-1:0], n)};
    endfunction

    function automatic logic [KEY_W-1:0] rotr56(input logic [KEY_W-1:0] cd, input logic [4:0] n);
        return {rotr28(cd[KEY_W-1:HALF_W], n), rotr28(cd[HALF_W-1:0], n)};
    endfunction

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                 state_q, state_d;
    logic [KEY_W-1:0]       cd_q, cd_d;
    logic [ROUND_IDX_W-1:0] idx_q, idx_d;
    logic                   mode_q, mode_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic                   last_c;
    logic [4:0]             step_enc_c, step_dec_c;

    assign last_c     = mode_q ? (idx_q == ROUND_IDX_W'(1)) : (idx_q == ROUND_IDX_W'(NUM_ROUNDS));
    assign step_enc_c = shamt(SCHED[idx_q]);
    assign step_dec_c = shamt(SCHED[idx_q - ROUND_IDX_W'(1)]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cd_q    <= '0;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Start is refused while o_done is still showing the previous schedule's end.
    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        if (ks.i_clear) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ks.i_start && !done_q) begin
                        state_d = ISSUE;
                        valid_d = 1'b1;
                        mode_d  = ks.i_decrypt;
                        if (ks.i_decrypt) begin
                            cd_d  = rotl56(ks.i_key, T_ROT);
                            idx_d = ROUND_IDX_W'(NUM_ROUNDS);
                        end else begin
                            cd_d  = rotl56(ks.i_key, shamt(SCHED[0]));
                            idx_d = ROUND_IDX_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    if (valid_q && ks.i_ready) begin
                        if (last_c) begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end else if (mode_q) begin
                            cd_d  = rotr56(cd_q, step_dec_c);
                            idx_d = idx_q - ROUND_IDX_W'(1);
                        end else begin
                            cd_d  = rotl56(cd_q, step_enc_c);
                            idx_d = idx_q + ROUND_IDX_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign ks.o_valid     = valid_q;
    assign ks.o_busy      = valid_q;
    assign ks.o_done      = done_q;
    assign ks.o_round_idx = idx_q;

    // PC-2, listed from output bit 48 down to output bit 1
    assign ks.o_round_key = {
        cd_q[31], cd_q[28], cd_q[35], cd_q[49], cd_q[41], cd_q[45],
        cd_q[52], cd_q[33], cd_q[55], cd_q[38], cd_q[48], cd_q[43],
        cd_q[47], cd_q[32], cd_q[44], cd_q[50], cd_q[39], cd_q[29],
        cd_q[54], cd_q[46], cd_q[36], cd_q[30], cd_q[51], cd_q[40],
        cd_q[1],  cd_q[12], cd_q[19], cd_q[26], cd_q[6],  cd_q[15],
        cd_q[7],  cd_q[25], cd_q[3],  cd_q[11], cd_q[18], cd_q[22],
        cd_q[9],  cd_q[20], cd_q[5],  cd_q[14], cd_q[27], cd_q[2],
        cd_q[4],  cd_q[0],  cd_q[23], cd_q[10], cd_q[16], cd_q[13]
    };
endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: three instances (16, 1 and 8 rounds) share one stimulus
// stream and are each checked every cycle against a round-number based key model.
module tb_des_key_schedule;
    localparam int NDUT = 3;
    localparam int NR [NDUT] = '{16, 1, 8};
    localparam logic [15:0] SCHED = 16'h7EFC;
    localparam int PC2 [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                                23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        decrypt = 1'b0;
    logic [55:0] key = '0;
    logic        clear = 1'b0;
    logic        ready = 1'b1;
    logic        cmp_en = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    des_key_schedule_if #(.ROUND_IDX_W(5)) ifs16 ();
    des_key_schedule_if #(.ROUND_IDX_W(5)) ifs1 ();
    des_key_schedule_if #(.ROUND_IDX_W(5)) ifs8 ();

    assign ifs16.i_start = start;  assign ifs1.i_start = start;  assign ifs8.i_start = start;
    assign ifs16.i_decrypt = decrypt; assign ifs1.i_decrypt = decrypt; assign ifs8.i_decrypt = decrypt;
    assign ifs16.i_key = key;      assign ifs1.i_key = key;      assign ifs8.i_key = key;
    assign ifs16.i_clear = clear;  assign ifs1.i_clear = clear;  assign ifs8.i_clear = clear;
    assign ifs16.i_ready = ready;  assign ifs1.i_ready = ready;  assign ifs8.i_ready = ready;

    des_key_schedule #(.NUM_ROUNDS(16), .SHIFT_SCHEDULE(SCHED), .ROUND_IDX_W(5))
        dut16 (.i_clk(clk), .i_rst(rst), .ks(ifs16));
    des_key_schedule #(.NUM_ROUNDS(1), .SHIFT_SCHEDULE(SCHED), .ROUND_IDX_W(5))
        dut1 (.i_clk(clk), .i_rst(rst), .ks(ifs1));
    des_key_schedule #(.NUM_ROUNDS(8), .SHIFT_SCHEDULE(SCHED), .ROUND_IDX_W(5))
        dut8 (.i_clk(clk), .i_rst(rst), .ks(ifs8));

    logic        dv [NDUT];
    logic        db [NDUT];
    logic        dd [NDUT];
    logic [47:0] dk [NDUT];
    logic [4:0]  di [NDUT];

    assign dv[0] = ifs16.o_valid; assign db[0] = ifs16.o_busy; assign dd[0] = ifs16.o_done;
    assign dk[0] = ifs16.o_round_key; assign di[0] = ifs16.o_round_idx;
    assign dv[1] = ifs1.o_valid;  assign db[1] = ifs1.o_busy;  assign dd[1] = ifs1.o_done;
    assign dk[1] = ifs1.o_round_key;  assign di[1] = ifs1.o_round_idx;
    assign dv[2] = ifs8.o_valid;  assign db[2] = ifs8.o_busy;  assign dd[2] = ifs8.o_done;
    assign dk[2] = ifs8.o_round_key;  assign di[2] = ifs8.o_round_idx;

    function automatic logic [27:0] rev28(input logic [27:0] x);
        logic [27:0] r;
        for (int i = 0; i < 28; i++) r[i] = x[27 - i];
        return r;
    endfunction

    function automatic logic [47:0] rev48(input logic [47:0] x);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[i] = x[47 - i];
        return r;
    endfunction

    // Round r key straight from the loaded key: cumulative rotation, then PC-2.
    function automatic logic [47:0] model_key(input logic [55:0] k, input int r);
        int sh;
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] out;
        sh = 0;
        for (int i = 0; i < r; i++) sh += SCHED[i] ? 2 : 1;
        sh = sh % 28;
        c = k[27:0];
        d = k[55:28];
        for (int i = 0; i < sh; i++) begin
            c = {c[0], c[27:1]};
            d = {d[0], d[27:1]};
        end
        cd = {d, c};
        for (int j = 0; j < 48; j++) out[j] = cd[PC2[j] - 1];
        return out;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timeout waiting (t=%0t)", nm, $time);
    endtask

    // Transaction-level model: which round each instance is presenting, if any.
    logic        m_act   [NDUT];
    logic        m_dec   [NDUT];
    logic        m_done  [NDUT];
    logic        m_fresh [NDUT];
    logic [55:0] m_key   [NDUT];
    int          m_pos   [NDUT];

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < NDUT; d++) begin
            if (rst) begin
                m_act[d]   <= 1'b0;
                m_dec[d]   <= 1'b0;
                m_done[d]  <= 1'b0;
                m_fresh[d] <= 1'b1;
                m_key[d]   <= '0;
                m_pos[d]   <= 0;
            end else if (clear) begin
                m_act[d]  <= 1'b0;
                m_done[d] <= 1'b0;
            end else if (!m_act[d]) begin
                m_done[d] <= 1'b0;
                if (start && !m_done[d]) begin
                    m_act[d]   <= 1'b1;
                    m_dec[d]   <= decrypt;
                    m_key[d]   <= key;
                    m_pos[d]   <= decrypt ? NR[d] : 1;
                    m_fresh[d] <= 1'b0;
                end
            end else begin
                m_done[d] <= 1'b0;
                if (ready) begin
                    if (m_dec[d] ? (m_pos[d] == 1) : (m_pos[d] == NR[d])) begin
                        m_act[d]  <= 1'b0;
                        m_done[d] <= 1'b1;
                    end else begin
                        m_pos[d] <= m_dec[d] ? m_pos[d] - 1 : m_pos[d] + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < NDUT; d++) begin
                chk($sformatf("valid[N=%0d]", NR[d]), 64'(dv[d]), 64'(m_act[d]));
                chk($sformatf("busy[N=%0d]", NR[d]), 64'(db[d]), 64'(m_act[d]));
                chk($sformatf("done[N=%0d]", NR[d]), 64'(dd[d]), 64'(m_done[d]));
                if (m_act[d]) begin
                    chk($sformatf("key[N=%0d,r=%0d]", NR[d], m_pos[d]), 64'(dk[d]),
                        64'(model_key(m_key[d], m_pos[d])));
                    chk($sformatf("idx[N=%0d]", NR[d]), 64'(di[d]), 64'(m_pos[d]));
                end else if (m_fresh[d]) begin
                    chk($sformatf("rst_key[N=%0d]", NR[d]), 64'(dk[d]), 64'd0);
                    chk($sformatf("rst_idx[N=%0d]", NR[d]), 64'(di[d]), 64'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic dec, input logic [55:0] k);
        start   = 1'b1;
        decrypt = dec;
        key     = k;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_idx16(input int target, input int budget);
        int n;
        n = 0;
        while (!(ifs16.o_valid && ifs16.o_round_idx == 5'(target))) begin
            if (n == budget) begin
                timeout_fail($sformatf("wait_idx_%0d", target));
                return;
            end
            tick();
            n++;
        end
    endtask

    task automatic wait_all_idle(input int budget);
        int n;
        n = 0;
        while (ifs16.o_busy || ifs16.o_done || ifs1.o_busy || ifs1.o_done ||
               ifs8.o_busy || ifs8.o_done) begin
            if (n == budget) begin
                timeout_fail("wait_all_idle");
                return;
            end
            tick();
            n++;
        end
    endtask

    initial begin
        logic [55:0] key0;
        logic [47:0] k1r, k2r, k16r;
        int hs;
        int n;

        key0 = {rev28(28'h556678F), rev28(28'hF0CCAAF)};
        k1r  = rev48(48'h1B02EFFC7072);
        k2r  = rev48(48'h79AED9DBC9E5);
        k16r = rev48(48'hCB3D8B0E17F5);

        chk("model_K1", 64'(model_key(key0, 1)), 64'(k1r));
        chk("model_K2", 64'(model_key(key0, 2)), 64'(k2r));
        chk("model_K16", 64'(model_key(key0, 16)), 64'(k16r));

        // reset state
        tick();
        tick();
        chk("reset_valid", 64'(ifs16.o_valid), 64'd0);
        chk("reset_busy", 64'(ifs16.o_busy), 64'd0);
        chk("reset_done", 64'(ifs16.o_done), 64'd0);
        chk("reset_key", 64'(ifs16.o_round_key), 64'd0);
        rst = 1'b0;
        cmp_en = 1'b1;
        tick();

        // encrypt, full speed; key/mode changes after start must not matter
        do_start(1'b0, key0);
        chk("enc_K1", 64'(ifs16.o_round_key), 64'(k1r));
        chk("enc_idx1", 64'(ifs16.o_round_idx), 64'd1);
        key = ~key0;
        decrypt = 1'b1;
        tick();
        chk("enc_K2", 64'(ifs16.o_round_key), 64'(k2r));
        chk("enc_idx2", 64'(ifs16.o_round_idx), 64'd2);
        for (int i = 0; i < 14; i++) tick();
        chk("enc_K16", 64'(ifs16.o_round_key), 64'(k16r));
        chk("enc_idx16", 64'(ifs16.o_round_idx), 64'd16);
        tick();
        chk("enc_done", 64'(ifs16.o_done), 64'd1);
        chk("enc_done_valid", 64'(ifs16.o_valid), 64'd0);
        // start during the o_done cycle is ignored
        start = 1'b1;
        decrypt = 1'b0;
        key = key0;
        tick();
        start = 1'b0;
        chk("start_in_done_ignored", 64'(ifs16.o_busy), 64'd0);
        chk("done_one_cycle", 64'(ifs16.o_done), 64'd0);
        wait_all_idle(40);

        // decrypt order
        do_start(1'b1, key0);
        chk("dec_first_K16", 64'(ifs16.o_round_key), 64'(k16r));
        chk("dec_first_idx", 64'(ifs16.o_round_idx), 64'd16);
        tick();
        chk("dec_K15", 64'(ifs16.o_round_key), 64'(model_key(key0, 15)));
        wait_idx16(1, 20);
        chk("dec_last_K1", 64'(ifs16.o_round_key), 64'(k1r));
        tick();
        chk("dec_done", 64'(ifs16.o_done), 64'd1);
        wait_all_idle(40);

        // backpressure with random ready
        do_start(1'b0, key0);
        hs = 0;
        n = 0;
        while (!ifs16.o_done && n < 300) begin
            ready = 1'($urandom_range(0, 1));
            if (ifs16.o_valid && ready) hs++;
            tick();
            n++;
        end
        if (n == 300) timeout_fail("backpressure_done");
        chk("bp_handshakes", 64'(hs), 64'd16);
        ready = 1'b1;
        wait_all_idle(40);

        // ignored start mid-schedule, then abort on the idx=5 handshake
        do_start(1'b0, key0);
        wait_idx16(2, 5);
        start = 1'b1;
        decrypt = 1'b1;
        tick();
        start = 1'b0;
        chk("mid_start_ignored_idx", 64'(ifs16.o_round_idx), 64'd3);
        wait_idx16(5, 10);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_valid", 64'(ifs16.o_valid), 64'd0);
        chk("clear_busy", 64'(ifs16.o_busy), 64'd0);
        chk("clear_no_done", 64'(ifs16.o_done), 64'd0);
        tick();
        chk("clear_no_done_later", 64'(ifs16.o_done), 64'd0);
        wait_all_idle(40);
        do_start(1'b0, key0);
        chk("after_clear_K1", 64'(ifs16.o_round_key), 64'(k1r));
        wait_all_idle(40);

        // asynchronous reset at idx=9
        do_start(1'b0, key0);
        wait_idx16(9, 20);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(ifs16.o_valid), 64'd0);
        chk("arst_busy", 64'(ifs16.o_busy), 64'd0);
        chk("arst_idx", 64'(ifs16.o_round_idx), 64'd0);
        chk("arst_key", 64'(ifs16.o_round_key), 64'd0);
        chk("arst_done", 64'(ifs16.o_done), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_done", 64'(ifs16.o_done), 64'd0);
        do_start(1'b0, key0);
        chk("post_rst_K1", 64'(ifs16.o_round_key), 64'(k1r));
        wait_all_idle(40);

        // parameter sweep: 1 and 8 rounds
        do_start(1'b0, key0);
        chk("n1_K1", 64'(ifs1.o_round_key), 64'(k1r));
        chk("n1_idx", 64'(ifs1.o_round_idx), 64'd1);
        chk("n8_K1", 64'(ifs8.o_round_key), 64'(k1r));
        tick();
        chk("n1_done", 64'(ifs1.o_done), 64'd1);
        chk("n1_valid_off", 64'(ifs1.o_valid), 64'd0);
        chk("n8_K2", 64'(ifs8.o_round_key), 64'(k2r));
        wait_all_idle(40);
        do_start(1'b1, key0);
        chk("n8_dec_first", 64'(ifs8.o_round_key), 64'(model_key(key0, 8)));
        chk("n8_dec_idx", 64'(ifs8.o_round_idx), 64'd8);
        chk("n1_dec_K1", 64'(ifs1.o_round_key), 64'(k1r));
        wait_all_idle(40);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Sequential DES round-key generator. Takes a 56-bit PC-1-permuted key, applies per-round C/D rotations and PC-2 compression, and issues one 48-bit round key per accepted handshake.
- Supports encrypt order (K1..KN) and decrypt order (KN..K1) from the same loaded key.
- Sits between key load logic and the round datapath, which consumes keys via valid/ready.

Parameters:
- NUM_ROUNDS, 16, number of round keys issued per schedule; legal range 1..16.
- SHIFT_SCHEDULE, 16'h7EFC, bit r-1 = 1 means round r rotates by 2, 0 means rotate by 1; only bits [NUM_ROUNDS-1:0] used.
- ROUND_IDX_W, 5, width of o_round_idx; must hold NUM_ROUNDS.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  start request; sampled only in IDLE.
- i_decrypt  input  1  mode qualifier, sampled with i_start: 0 = encrypt order, 1 = decrypt order.
- i_key  input  56  PC-1 output, sampled with i_start. Bit 0 = DES bit 1; C = i_key[27:0], D = i_key[55:28].
- i_clear  input  1  synchronous abort.
- i_ready  input  1  consumer ready.
- o_valid  output  1  o_round_key / o_round_idx valid.
- o_round_key  output  48  PC-2(C,D); bit 0 = DES PC-2 output bit 1.
- o_round_idx  output  ROUND_IDX_W  DES round number (1..NUM_ROUNDS) of the current key.
- o_busy  output  1  high while not IDLE.
- o_done  output  1  one-cycle pulse after the final key handshake.

Behaviour:
- Reset (async, i_rst=1): state=IDLE; C/D register, step counter and mode cleared; o_valid=0, o_round_idx=0, o_busy=0, o_done=0; o_round_key = PC-2 of an all-zero register = 0.
- Rotation conventions, per 28-bit half, bit 0 = DES bit 1:
  - rotL by n: new[k] = old[(k+n) mod 28].
  - rotR by n: new[k] = old[(k-n) mod 28].
- T = (sum of the NUM_ROUNDS schedule shifts) mod 28; an elaboration-time constant. The default gives T = 0.
- FSM states: IDLE, ISSUE.
- IDLE, i_start=1 at edge E:
  - mode := i_decrypt.
  - Encrypt: CD := rotL(i_key, s1); idx := 1.
  - Decrypt: CD := rotL(i_key, T); idx := NUM_ROUNDS.
  - Go to ISSUE. o_valid=1 and o_busy=1 from E onward; first key visible the cycle after the start cycle.
- o_round_key is PC-2 of the CD register: combinational from registers, no added latency.
- ISSUE, handshake (o_valid & i_ready) at an edge:
  - If not the last key: advance one step, so the next key is valid the following cycle. Throughput is 1 key/cycle with i_ready held high.
    - Encrypt: idx := idx+1; CD := rotL(CD, s_idx+1).
    - Decrypt: CD := rotR(CD, s_idx); idx := idx-1.
  - If last key (encrypt idx=NUM_ROUNDS, decrypt idx=1): go to IDLE, o_valid:=0, o_busy:=0, o_done:=1 for exactly one cycle.
- Backpressure: with i_ready=0, o_valid stays high and o_round_key / o_round_idx hold stable.
- i_start outside IDLE is ignored, including during the o_done cycle; a new start is accepted the cycle after o_done deasserts.
- Changes to i_key or i_decrypt mid-schedule have no effect.
- i_clear=1 at an edge, in any state: go to IDLE, o_valid=0, o_busy=0, o_done=0. i_clear has priority over a handshake and over i_start in the same cycle.
- NUM_ROUNDS=1: one key issued, then o_done.
- i_rst asserted mid-schedule: outputs go to reset values immediately, with no o_done.

Test Plan:
- Encrypt, key 64'h133457799BBCDFF1: load its PC-1 (C0 = 28'hF0CCAAF, D0 = 28'h556678F, DES bit order), i_ready=1.
  - Required: K1 = 48'h1B02EFFC7072, K2 = 48'h79AED9DBC9E5, K16 = 48'hCB3D8B0E17F5 (DES bit order), idx 1..16 on consecutive cycles.
  - Required: o_done one cycle after K16 handshake.
- Decrypt, same key: first key = 48'hCB3D8B0E17F5 with idx=16, second = K15, last = 48'h1B02EFFC7072 with idx=1; all 16 match the encrypt run reversed.
- Backpressure: i_ready toggled randomly.
  - Required: key and idx hold while i_ready=0; no key skipped or duplicated; exactly 16 handshakes.
- Abort and ignored start: i_start during ISSUE is ignored; i_clear with i_ready=1 at the idx=5 handshake.
  - Required: o_valid=0 and o_busy=0 next cycle; no o_done.
  - Required: a fresh start then yields K1 again.
- Reset mid-schedule: assert i_rst asynchronously at idx=9.
  - Required: o_valid, o_busy, o_round_idx and o_round_key = 0 immediately, before the next clock edge.
  - Required: after release, normal operation on the next start.
- Parameter sweep: NUM_ROUNDS=1 emits only K1 then o_done; NUM_ROUNDS=8 with default schedule emits the same K1..K8, and its decrypt run starts at rotL(CD0, T=14).
